watch_ctrl: RTL and testbench

WATCH_CTRL -- requirements
Module: watch_ctrl

---
 rtl/watch_pkg.sv | 32 +++
 rtl/watch_ctrl_if.sv | 9 +
 rtl/key_debounce.sv | 45 ++++
 rtl/watch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_watch_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - state encoding, timing constants and digit helpers for watch_ctrl
package watch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_LAP   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_SET   = 3'd4
   } state_t;

   localparam int DEBOUNCE_CYCLES = 20;
   localparam int BLINK_HALF      = 250;

   // Tens-of-seconds (3) and tens-of-minutes (5) stop at 5; every other digit at 9.
   function automatic logic [3:0] digit_limit(input logic [2:0] idx);
      return (idx == 3'd3 || idx == 3'd5) ? 4'd5 : 4'd9;
   endfunction

   // Values at or above the limit (including non-BCD) wrap to 0; no carry.
   function automatic logic [23:0] inc_digit(input logic [23:0] val, input logic [2:0] idx);
      logic [23:0] res;
      logic [3:0]  d;
      res = val;
      d   = val[4*idx +: 4];
      if (d >= digit_limit(idx)) d = 4'd0;
      else                       d = d + 4'd1;
      res[4*idx +: 4] = d;
      return res;
   endfunction

endpackage

// File: rtl/watch_ctrl_if.sv
// rtl/watch_ctrl_if.sv - one key channel: raw level in, debounced level and press pulse out
interface watch_ctrl_if;
   logic raw;
   logic level;
   logic press;

   modport deb  (input raw, output level, output press);
   modport user (output raw, input level, input press);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - accepts a key level after DEBOUNCE_CYCLES stable samples, pulses on accepted press
module key_debounce
   import watch_pkg::*;
(
   input  logic        clk_1Khz,
   input  logic        rst,
   watch_ctrl_if.deb   key
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (key.raw != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = key.raw;
            press_d = key.raw;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_1Khz or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign key.level = level_q;
   assign key.press = press_q;

endmodule

// File: rtl/watch_ctrl.sv
// rtl/watch_ctrl.sv - stopwatch control FSM: run/lap/pause/set with debounced keys
// Optional digit blinking in SET is built when WATCH_CTRL_BLINK_EN is defined.
module watch_ctrl
   import watch_pkg::*;
(
   input  logic        clk_1Khz,
   input  logic        rst,
   input  logic        key_start,
   input  logic        key_lap,
   input  logic        key_set,
   input  logic [23:0] dispbuf_in,
   output logic        EN,
   output logic        load,
   output logic [23:0] preset,
   output logic [23:0] disp_out,
   output logic [2:0]  state_o,
   output logic [2:0]  digit_sel
);

   watch_ctrl_if k_start ();
   watch_ctrl_if k_lap ();
   watch_ctrl_if k_set ();

   assign k_start.raw = key_start;
   assign k_lap.raw   = key_lap;
   assign k_set.raw   = key_set;

   key_debounce u_deb_start (.clk_1Khz(clk_1Khz), .rst(rst), .key(k_start));
   key_debounce u_deb_lap   (.clk_1Khz(clk_1Khz), .rst(rst), .key(k_lap));
   key_debounce u_deb_set   (.clk_1Khz(clk_1Khz), .rst(rst), .key(k_set));

   logic unused_levels;
   assign unused_levels = k_start.level ^ k_lap.level ^ k_set.level;

   logic set_p, start_p, lap_p;
   assign set_p   = k_set.press;
   assign start_p = k_start.press & ~k_set.press;
   assign lap_p   = k_lap.press & ~k_start.press & ~k_set.press;

   state_t      state_q, state_d;
   logic [23:0] preset_q, preset_d;
   logic [23:0] snap_q, snap_d;
   logic [2:0]  sel_q, sel_d;
   logic        load_q, load_d;
   logic [23:0] set_view;

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      snap_d   = snap_q;
      sel_d    = sel_q;
      load_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (set_p) begin
               state_d  = ST_SET;
               preset_d = dispbuf_in;
               sel_d    = 3'd0;
            end else if (start_p) begin
               state_d = ST_RUN;
            end else if (lap_p) begin
               preset_d = '0;
               load_d   = 1'b1;
            end
         end
         ST_RUN: begin
            if (start_p) begin
               state_d = ST_PAUSE;
            end else if (lap_p) begin
               state_d = ST_LAP;
               snap_d  = dispbuf_in;
            end
         end
         ST_LAP: begin
            if (start_p) begin
               state_d = ST_PAUSE;
               snap_d  = '0;
            end else if (lap_p) begin
               state_d = ST_RUN;
               snap_d  = '0;
            end
         end
         ST_PAUSE: begin
            if (set_p) begin
               state_d  = ST_SET;
               preset_d = dispbuf_in;
               sel_d    = 3'd0;
            end else if (start_p) begin
               state_d = ST_RUN;
            end else if (lap_p) begin
               state_d  = ST_IDLE;
               preset_d = '0;
               load_d   = 1'b1;
            end
         end
         ST_SET: begin
            if (set_p) begin
               state_d = ST_IDLE;
               load_d  = 1'b1;
            end else if (start_p) begin
               sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
            end else if (lap_p) begin
               preset_d = inc_digit(preset_q, sel_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_1Khz or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         preset_q <= '0;
         snap_q   <= '0;
         sel_q    <= 3'd0;
         load_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         preset_q <= preset_d;
         snap_q   <= snap_d;
         sel_q    <= sel_d;
         load_q   <= load_d;
      end
   end

`ifdef WATCH_CTRL_BLINK_EN
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       blank_q, blank_d;

   // Phase restarts on any digit_sel change so the newly selected digit starts visible.
   always_comb begin
      blink_cnt_d = blink_cnt_q + 8'd1;
      blank_d     = blank_q;
      if (state_q != ST_SET || sel_d != sel_q) begin
         blink_cnt_d = '0;
         blank_d     = 1'b0;
      end else if (blink_cnt_q == 8'(BLINK_HALF - 1)) begin
         blink_cnt_d = '0;
         blank_d     = ~blank_q;
      end
   end

   always_ff @(posedge clk_1Khz or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blank_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blank_q     <= blank_d;
      end
   end

   always_comb begin
      set_view = preset_q;
      if (blank_q) set_view[4*sel_q +: 4] = 4'hF;
   end
`else
   assign set_view = preset_q;
`endif

   always_comb begin
      case (state_q)
         ST_LAP:  disp_out = snap_q;
         ST_SET:  disp_out = set_view;
         default: disp_out = dispbuf_in;
      endcase
   end

   assign EN        = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign load      = load_q;
   assign preset    = preset_q;
   assign state_o   = state_q;
   assign digit_sel = sel_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// tb/tb_watch_ctrl.sv - directed self-checking bench for watch_ctrl
module tb_watch_ctrl;

   logic        clk_1Khz = 1'b0;
   logic        rst;
   logic        key_start, key_lap, key_set;
   logic [23:0] dispbuf_in;
   logic        EN, load;
   logic [23:0] preset, disp_out;
   logic [2:0]  state_o, digit_sel;

   int checks = 0;
   int errors = 0;
   int start_presses = 0;

   watch_ctrl dut (
      .clk_1Khz   (clk_1Khz),
      .rst        (rst),
      .key_start  (key_start),
      .key_lap    (key_lap),
      .key_set    (key_set),
      .dispbuf_in (dispbuf_in),
      .EN         (EN),
      .load       (load),
      .preset     (preset),
      .disp_out   (disp_out),
      .state_o    (state_o),
      .digit_sel  (digit_sel)
   );

   always #5 clk_1Khz = ~clk_1Khz;

   always @(posedge clk_1Khz) if (dut.k_start.press) start_presses++;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_1Khz);
   endtask

   // Hold keys 21 cycles: pulse after the 20th edge, FSM updates on the 21st.
   task automatic hold(input logic s, input logic l, input logic t);
      key_start = s;
      key_lap   = l;
      key_set   = t;
      step(21);
   endtask

   task automatic rel();
      key_start = 1'b0;
      key_lap   = 1'b0;
      key_set   = 1'b0;
      step(20);
   endtask

   initial begin
      rst        = 1'b1;
      key_start  = 1'b0;
      key_lap    = 1'b0;
      key_set    = 1'b0;
      dispbuf_in = 24'h000000;
      step(2);
      chk("reset_state", 24'(state_o), 24'd0);
      chk("reset_en", 24'(EN), 24'd0);
      chk("reset_load", 24'(load), 24'd0);
      chk("reset_preset", preset, 24'h000000);
      chk("reset_sel", 24'(digit_sel), 24'd0);
      rst = 1'b0;
      step(1);

      // Bouncing start key: two 5-cycle glitches must not be accepted
      for (int i = 0; i < 2; i++) begin
         key_start = 1'b1; step(5);
         key_start = 1'b0; step(5);
      end
      chk("bounce_state", 24'(state_o), 24'd0);
      key_start = 1'b1;
      step(20);
      chk("press_pulse_en_not_yet", 24'(EN), 24'd0);
      step(1);
      chk("run_en", 24'(EN), 24'd1);
      chk("run_state", 24'(state_o), 24'd1);
      rel();
      chk("one_press", 24'(start_presses), 24'd1);

      // Lap snapshot
      dispbuf_in = 24'h012345;
      hold(1'b0, 1'b1, 1'b0);
      chk("lap_state", 24'(state_o), 24'd2);
      dispbuf_in = 24'h000777;
      step(1);
      chk("lap_hold", disp_out, 24'h012345);
      rel();
      chk("lap_hold_late", disp_out, 24'h012345);
      chk("lap_en", 24'(EN), 24'd1);
      hold(1'b0, 1'b1, 1'b0);
      chk("lap_release_state", 24'(state_o), 24'd1);
      chk("lap_release_disp", disp_out, 24'h000777);
      rel();

      hold(1'b1, 1'b0, 1'b0);
      chk("pause_state", 24'(state_o), 24'd3);
      chk("pause_en", 24'(EN), 24'd0);
      rel();

      // Simultaneous set+start in PAUSE: set wins, start dropped
      hold(1'b1, 1'b0, 1'b1);
      chk("prio_state", 24'(state_o), 24'd4);
      step(1);
      chk("prio_sel", 24'(digit_sel), 24'd0);
      chk("prio_preset", preset, 24'h000777);
      rel();
      hold(1'b0, 1'b0, 1'b1);
      chk("set_exit_state", 24'(state_o), 24'd0);
      chk("set_exit_load", 24'(load), 24'd1);
      rel();

      // Digit editing
      dispbuf_in = 24'h593999;
      hold(1'b0, 1'b0, 1'b1);
      chk("set_entry_preset", preset, 24'h593999);
      chk("set_entry_disp", disp_out, 24'h593999);
      rel();
      for (int i = 0; i < 3; i++) begin
         hold(1'b1, 1'b0, 1'b0);
         rel();
      end
      chk("sel_3", 24'(digit_sel), 24'd3);
      hold(1'b0, 1'b1, 1'b0);
      chk("inc_idx3", preset, 24'h594999);
      chk("inc_idx3_disp", disp_out, 24'h594999);
      rel();
      hold(1'b0, 1'b0, 1'b1);
      chk("set_load", 24'(load), 24'd1);
      chk("set_load_preset", preset, 24'h594999);
      chk("set_load_state", 24'(state_o), 24'd0);
      step(1);
      chk("set_load_one_cycle", 24'(load), 24'd0);
      rel();

      // Clear from PAUSE
      hold(1'b1, 1'b0, 1'b0); rel();
      hold(1'b1, 1'b0, 1'b0); rel();
      chk("pause2_state", 24'(state_o), 24'd3);
      hold(1'b0, 1'b1, 1'b0);
      chk("clear_preset", preset, 24'h000000);
      chk("clear_load", 24'(load), 24'd1);
      chk("clear_state", 24'(state_o), 24'd0);
      chk("clear_en", 24'(EN), 24'd0);
      step(1);
      chk("clear_load_one_cycle", 24'(load), 24'd0);
      rel();

      // Wrap rules across all six digits: {3,5,5,9,A,9}
      dispbuf_in = 24'h3559A9;
      hold(1'b0, 1'b0, 1'b1); rel();
      hold(1'b0, 1'b1, 1'b0); rel();
      chk("wrap_idx0_9", preset, 24'h3559A0);
      hold(1'b1, 1'b0, 1'b0); rel();
      hold(1'b0, 1'b1, 1'b0); rel();
      chk("wrap_idx1_nonbcd", preset, 24'h355900);
      hold(1'b1, 1'b0, 1'b0); rel();
      hold(1'b0, 1'b1, 1'b0); rel();
      chk("wrap_idx2_9", preset, 24'h355000);
      hold(1'b1, 1'b0, 1'b0); rel();
      hold(1'b0, 1'b1, 1'b0); rel();
      chk("wrap_idx3_5", preset, 24'h350000);
      hold(1'b1, 1'b0, 1'b0); rel();
      hold(1'b0, 1'b1, 1'b0); rel();
      chk("inc_idx4_5", preset, 24'h360000);
      hold(1'b1, 1'b0, 1'b0); rel();
      hold(1'b0, 1'b1, 1'b0); rel();
      chk("inc_idx5_3", preset, 24'h460000);
      hold(1'b1, 1'b0, 1'b0); rel();
      chk("sel_wrap", 24'(digit_sel), 24'd0);
      hold(1'b0, 1'b0, 1'b1); rel();
      chk("wrap_exit_state", 24'(state_o), 24'd0);

      // Async reset mid-RUN with a lap key part-way through debounce
      hold(1'b1, 1'b0, 1'b0); rel();
      chk("pre_rst_run", 24'(state_o), 24'd1);
      key_lap = 1'b1;
      step(10);
      #2 rst = 1'b1;
      key_lap = 1'b0;
      #1;
      chk("arst_state", 24'(state_o), 24'd0);
      chk("arst_en", 24'(EN), 24'd0);
      chk("arst_preset", preset, 24'h000000);
      chk("arst_load", 24'(load), 24'd0);
      chk("arst_sel", 24'(digit_sel), 24'd0);
      step(1);
      rst = 1'b0;
      step(30);
      chk("post_rst_idle", 24'(state_o), 24'd0);
      chk("post_rst_disp", disp_out, 24'h3559A9);

`ifdef WATCH_CTRL_BLINK_EN
      dispbuf_in = 24'h123456;
      hold(1'b0, 1'b0, 1'b1);
      chk("blink_visible0", disp_out, 24'h123456);
      step(249);
      chk("blink_visible_end", disp_out, 24'h123456);
      step(1);
      chk("blink_blank", disp_out, 24'h12345F);
      step(250);
      chk("blink_visible_again", disp_out, 24'h123456);
      key_set = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
